// File: rtl/cnt_up_if.sv
// Control/data bundle for the cnt_up counter: load/enable controls, load value, and count output.
interface cnt_up_if #(
  parameter int SIZE_ = 8
);
  logic             en_;
  logic             load_cnt_;
  logic [SIZE_-1:0] d_;
  logic [SIZE_-1:0] q_;

  // The controller drives the controls; the counter returns its registered count.
  modport master (output en_, output load_cnt_, output d_, input q_);
  modport slave  (input en_, input load_cnt_, input d_, output q_);
endinterface

// File: rtl/cnt_up.sv
// Synchronous up-counter with parallel load, used as the factorial iteration/index counter.
// Priority at each edge: reset, then load, then increment (wrapping), else hold.
module cnt_up #(
  parameter int SIZE_ = 8
) (
  input  logic     clk_,
  input  logic     rst_,
  cnt_up_if.slave  bus_
);

  logic [SIZE_-1:0] q_q;
  logic [SIZE_-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (bus_.load_cnt_) begin
      q_d = bus_.d_;
    end else if (bus_.en_) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_) begin
    if (rst_) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // The output comes straight from the register, so downstream compare logic sees no input path.
  assign bus_.q_ = q_q;

endmodule

// File: tb/tb_cnt_up.sv
// Scoreboard bench for cnt_up: an 8-bit and a 4-bit instance driven in lockstep.
module tb_cnt_up;

  logic clk;
  logic rst;

  cnt_up_if #(.SIZE_(8)) bus8 ();
  cnt_up_if #(.SIZE_(4)) bus4 ();

  cnt_up #(.SIZE_(8)) dut8 (.clk_(clk), .rst_(rst), .bus_(bus8));
  cnt_up #(.SIZE_(4)) dut4 (.clk_(clk), .rst_(rst), .bus_(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp8_q [$];
  logic [7:0] exp4_q [$];
  string      tag_q  [$];

  logic [7:0] m8;
  logic [3:0] m4;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, queue the model's
  // prediction, then compare just after the rising edge.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [7:0] d, input string tag);
    logic [7:0] prev8;
    logic [3:0] prev4;
    string      t;
    @(negedge clk);
    prev8 = m8;
    prev4 = m4;
    rst = r;
    bus8.en_ = e; bus8.load_cnt_ = l; bus8.d_ = d;
    bus4.en_ = e; bus4.load_cnt_ = l; bus4.d_ = d[3:0];
    if (r)      begin m8 = 8'h00; m4 = 4'h0; end
    else if (l) begin m8 = d;     m4 = d[3:0]; end
    else if (e) begin m8 = m8 + 8'd1; m4 = m4 + 4'd1; end
    exp8_q.push_back(m8);
    exp4_q.push_back({4'h0, m4});
    tag_q.push_back(tag);
    #1;
    // Outputs must not follow inputs between edges.
    if (!$isunknown(prev8)) begin
      check({tag, "/hold8"}, bus8.q_, prev8);
      check({tag, "/hold4"}, {4'h0, bus4.q_}, {4'h0, prev4});
    end
    @(posedge clk);
    #1;
    t = tag_q.pop_front();
    check({t, "/8"}, bus8.q_, exp8_q.pop_front());
    check({t, "/4"}, {4'h0, bus4.q_}, exp4_q.pop_front());
  endtask

  initial begin
    rst = 1'b0;
    bus8.en_ = 1'b0; bus8.load_cnt_ = 1'b0; bus8.d_ = '0;
    bus4.en_ = 1'b0; bus4.load_cnt_ = 1'b0; bus4.d_ = '0;
    m8 = 'x;
    m4 = 'x;

    step(1, 1, 0, 8'h00, "rst0");
    step(1, 1, 0, 8'h00, "rst1");

    step(0, 0, 1, 8'h00, "ld0a");
    step(0, 0, 1, 8'h00, "ld0b");
    step(0, 1, 0, 8'h00, "inc1");
    step(0, 1, 0, 8'h00, "inc2");

    step(0, 0, 1, 8'h10, "ld10");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, "hold");
    step(0, 1, 1, 8'h05, "pri");

    step(0, 0, 1, 8'hFE, "ldfe");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, "wrap");

    step(0, 0, 1, 8'h06, "ld06");
    step(0, 1, 0, 8'h00, "to07");
    step(1, 1, 1, 8'hAA, "rstld");
    step(0, 1, 0, 8'h00, "post");

    step(0, 0, 1, 8'h0F, "ldf");
    step(0, 1, 0, 8'h00, "w4inc");
    step(0, 0, 1, 8'h0A, "lda");

    for (int i = 0; i < 30; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_up.md
# cnt_up

Parameterized synchronous up-counter with parallel load, used as the iteration/index counter in the factorial datapath. A controller either loads a start value from `d_` or lets the counter increment once per enabled clock. Output `q_` is fully registered and is read directly by downstream datapath logic and the controller's compare logic.

## Interface

Parameters:
- `SIZE_`, default 8: counter width in bits. Must be ≥ 1.

Ports:
- `clk_`  input  1  sole clock. All state updates on its rising edge.
- `rst_`  input  1  reset. One clock; reset is synchronous and active-high.
- `en_`  input  1  count enable. When high and not loading, `q_` increments by 1 each clock.
- `load_cnt_`  input  1  parallel load. When high, `q_` takes `d_` on the next edge.
- `d_`  input  `SIZE_`  load value.
- `q_`  output  `SIZE_`  current count, driven directly from the state register.

## Operation

- Single `SIZE_`-bit register drives `q_`. No combinational path from inputs to `q_`.
- Priority of actions at each rising edge of `clk_`, highest first:
  1. `rst_`=1: `q_` ← 0.
  2. `load_cnt_`=1: `q_` ← `d_`. The value of `en_` does not matter.
  3. `en_`=1: `q_` ← `q_` + 1, modulo 2^`SIZE_`.
  4. Otherwise: `q_` holds.
- Load does not need enable. This lets the controller initialize the counter while counting is disabled.
- Load and enable together: the load wins and no increment occurs that cycle.
- Wrap-around: when `q_` = 2^`SIZE_`−1 and the counter increments, the next value is 0. There is no terminal-count flag and no saturation.
- Arithmetic is unsigned. `d_` is loaded verbatim at full width.
- Reset mid-count or during a load: reset wins, and `q_` = 0 after that edge.
- Before the first reset or load, `q_` is undefined. Users must reset or load before relying on the value.

## Timing

- Latency for reset, load and increment: 1 cycle each. The new `q_` is visible just after the rising edge that samples the inputs.
- Inputs are sampled only at the rising edge. Changes between edges have no effect.
- One increment per enabled cycle. Back-to-back enabled cycles give consecutive values.
- Reset value of `q_`: 0.
- Benches must change stimulus away from active edges, for example on the falling edge.

## Test plan

- Reset: assert `rst_`=1 for 2 cycles with `load_cnt_`=0 and `en_`=1 → `q_`=0 after the first edge, and it stays 0 while reset is high.
- Load with counting disabled: `en_`=0, `load_cnt_`=1, `d_`=0 for 2 cycles → `q_`=0. Then set `en_`=1, `load_cnt_`=0 → `q_`=1 after one edge and 2 after the second.
- Hold and priority:
  - Load `d_`=0x10, then `en_`=0, `load_cnt_`=0 for 3 cycles → `q_` stays 0x10.
  - Set `en_`=1, `load_cnt_`=1, `d_`=0x05 → `q_`=0x05, not 0x11.
- Wrap-around (`SIZE_`=8): load 0xFE, then enable for 3 cycles → `q_` sequence 0xFF, 0x00, 0x01.
- Reset mid-operation: counting at `q_`=0x07 with `en_`=1, assert `rst_` together with `load_cnt_`=1, `d_`=0xAA → `q_`=0x00. After releasing reset with `en_`=1, `load_cnt_`=0 → `q_`=0x01.
- Width check (`SIZE_`=4): load 0xF, enable 1 cycle → `q_`=0x0. Load 0xA → `q_`=0xA.
